mul_sqrt_2: RTL and testbench
=============================

# mul_sqrt_2

Pipelined multiply of a signed fixed-point sample by √2 using arithmetic shifts and adds, with valid/ready flow control. It is the inverse of the existing divide-by-√2 stage: the inverse-FFT and denormalisation paths use it to undo the 1/√2 scaling applied to the W8 twiddle products. It saturates to the signed W-bit range and flags saturation.

## Interface
- N, default 4, log2 of data width; W = 2**N (16 by default).
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  `a` holds a sample to accept.
- in_ready  output  1  block can accept `a` this cycle.
- a  input  W  signed two's-complement sample.
- out_valid  output  1  `result` holds a product.
- out_ready  input  1  downstream accepts `result` this cycle.
- result  output  W  signed product, saturated.
- sat  output  1  `result` was clipped; qualified by out_valid.

## Operation
- Coefficient √2 ≈ 1 + 2^-2 + 2^-3 + 2^-5 + 2^-7 + 2^-13 = 1.4141846.
- All terms are `a >>> k`, arithmetic right shifts with floor truncation and no rounding, each sign-extended to W+2 bits. All internal sums are W+2 bits and cannot overflow.
- Stage 1 registers three values: p0 = a + (a>>>2), p1 = (a>>>3) + (a>>>5), p2 = (a>>>7) + (a>>>13).
- Stage 2 registers two values: q0 = p0 + p1 and q1 = p2.
- Stage 3:
  - Sum s = q0 + q1.
  - If s > 2^(W-1)-1, result = 2^(W-1)-1 and sat = 1.
  - If s < -2^(W-1), result = -2^(W-1) and sat = 1.
  - Otherwise result = s[W-1:0] and sat = 0.
  - result and sat are registered.
- Each stage holds a valid bit: v1, v2, v3, with out_valid = v3.
- Flow control is a global stall, with no bubble collapsing:
  - en = !v3 | out_ready.
  - in_ready = en.
  - When en = 1, every stage advances: v1 ← in_valid, v2 ← v1, v3 ← v2.
  - When en = 0, all stage registers and valid bits hold.
- Data registers load on en regardless of the valid bits. Invalid slots carry don't-care data, except that result and sat must not change while v3 = 1 and out_ready = 0.
- Reset (async, any time including mid-stream):
  - v1, v2 and v3 clear to 0.
  - All data registers, result and sat clear to 0.
  - in_ready = 1 while rst is deasserted and the pipe is empty.
  - In-flight samples are discarded. There is no recovery or replay.

## Timing
- Latency is 3 cycles. A sample accepted at edge k (in_valid & in_ready) appears with out_valid = 1 after edge k+2, provided no stall occurs.
- Throughput is 1 sample per cycle while out_ready = 1.
- in_ready is combinational from out_ready and v3. There is no combinational path from in_valid to any output.
- Backpressure example: with out_valid = 1 and out_ready = 0, in_ready = 0 and all three stages freeze. On the first cycle out_ready returns to 1, the output handshake completes and the pipe advances at the same edge.
- Simultaneous events:
  - Output handshake and input acceptance in the same cycle are legal and required at full rate.
  - An empty slot (v = 0) moving through the pipe behaves as normal data flow.

## Structure
- Shared package fft_pkg holds two items:
  - the √2 shift list, as constants SQ2_K0..SQ2_K5 = 0, 2, 3, 5, 7, 13;
  - a guard-width constant GUARD = 2.
- Shifts reuse the existing arithmetic-shift module, one instance per term. Register stages reuse the existing N-parameterised register with an added enable.
- New sub-module sat_n (W+2 → W signed clip plus flag), placed in its own file for reuse by the butterfly output stage.

## Test plan
- Scenario 1, basic products: with out_ready = 1, stream a = 0x1000 then 0xF000.
  - Outputs 3 cycles later are result = 5792 (0x16A0) and then -5793 (0xE95F).
  - sat = 0 for both.
- Scenario 2, small values and truncation bias: stream a = 1, -1, 0.
  - Results are 1, -6 and 0.
- Scenario 3, saturation:
  - a = 0x7FFF gives result = 0x7FFF with sat = 1 (raw s = 46334).
  - a = 0x8000 gives result = 0x8000 with sat = 1 (raw s = -46340).
- Scenario 4, backpressure: stream 5 samples back-to-back and drop out_ready for 4 cycles when the first reaches the output.
  - in_ready = 0 during the stall.
  - result and sat stay stable while out_ready is low.
  - All 5 outputs arrive in order with none lost or duplicated.
- Scenario 5, reset mid-stream: assert rst asynchronously with 3 samples in flight.
  - out_valid, result and sat go to 0 immediately.
  - After release, no stale outputs appear.
  - The next accepted sample emerges after 3 cycles.
- Scenario 6, random soak: 10k random samples with random in_valid and out_ready.
  - Compare against a reference model of the shift-sum plus saturation.
  - Require exact match and the same output order.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT constants: the sqrt(2) shift-add term list and internal guard width.
package fft_pkg;

    localparam int SQ2_K0 = 0;
    localparam int SQ2_K1 = 2;
    localparam int SQ2_K2 = 3;
    localparam int SQ2_K3 = 5;
    localparam int SQ2_K4 = 7;
    localparam int SQ2_K5 = 13;

    localparam int SQ2_NTERMS = 6;

    // Headroom above the sample width so the shift-add sums never wrap.
    localparam int GUARD = 2;

    function automatic int sq2_k(input int idx);
        case (idx)
            0:       return SQ2_K0;
            1:       return SQ2_K1;
            2:       return SQ2_K2;
            3:       return SQ2_K3;
            4:       return SQ2_K4;
            default: return SQ2_K5;
        endcase
    endfunction

endpackage

// File: rtl/mul_sqrt_2_if.sv
// Sample-in / product-out valid-ready bundle for the multiply-by-sqrt(2) stage.
interface mul_sqrt_2_if #(
    parameter int N = 4
) ();
    localparam int W = 2**N;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         sat;

    modport slave (
        input  in_valid, a, out_ready,
        output in_ready, out_valid, result, sat
    );

    modport master (
        output in_valid, a, out_ready,
        input  in_ready, out_valid, result, sat
    );
endinterface

// File: rtl/asr_n.sv
// Arithmetic right shift by a fixed K, sign-extended into GUARD extra bits.
// Combinational; floor truncation, no rounding.
module asr_n
    import fft_pkg::*;
#(
    parameter int N = 4,
    parameter int K = 0
) (
    input  logic [2**N-1:0]       a_i,
    output logic [2**N+GUARD-1:0] y_o
);
    localparam int W  = 2**N;
    localparam int WI = W + GUARD;

    logic signed [WI-1:0] ext;

    assign ext = {{GUARD{a_i[W-1]}}, a_i};
    assign y_o = ext >>> K;

endmodule

// File: rtl/reg_n_en.sv
// Width-parameterised register with load enable and async active-high clear.
module reg_n_en #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_o <= '0;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/sat_n.sv
// Signed clip from W+GUARD bits down to W bits, flagging when clipping occurred.
// Combinational.
module sat_n
    import fft_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [2**N+GUARD-1:0] s_i,
    output logic [2**N-1:0]       y_o,
    output logic                  sat_o
);
    localparam int W  = 2**N;
    localparam int WI = W + GUARD;

    // The value fits in W bits only if every bit from W-1 upward matches the sign.
    logic [GUARD:0] top;
    logic           over_hi;
    logic           over_lo;

    assign top     = s_i[WI-1:W-1];
    assign over_hi = !s_i[WI-1] && (top != '0);
    assign over_lo =  s_i[WI-1] && (top != '1);

    always_comb begin
        y_o   = s_i[W-1:0];
        sat_o = 1'b0;
        if (over_hi) begin
            y_o   = {1'b0, {(W-1){1'b1}}};
            sat_o = 1'b1;
        end else if (over_lo) begin
            y_o   = {1'b1, {(W-1){1'b0}}};
            sat_o = 1'b1;
        end
    end

endmodule

// File: rtl/mul_sqrt_2.sv
// Multiply signed sample by sqrt(2) via shift-add, saturating; 3-cycle latency, 1/cycle.
// Global stall: the whole pipe freezes while out_valid is high and out_ready is low.
module mul_sqrt_2
    import fft_pkg::*;
#(
    parameter int N = 4
) (
    input  logic          clk,
    input  logic          rst,
    mul_sqrt_2_if.slave   bus
);
    localparam int W  = 2**N;
    localparam int WI = W + GUARD;

    logic          en;
    logic [2:0]    v_d;
    logic [2:0]    v_q;

    logic [WI-1:0] term [SQ2_NTERMS];

    logic [3*WI-1:0] st1_d;
    logic [3*WI-1:0] st1_q;
    logic [2*WI-1:0] st2_d;
    logic [2*WI-1:0] st2_q;
    logic [W:0]      st3_d;
    logic [W:0]      st3_q;

    logic [WI-1:0] p0_q;
    logic [WI-1:0] p1_q;
    logic [WI-1:0] p2_q;
    logic [WI-1:0] q0_q;
    logic [WI-1:0] q1_q;
    logic [WI-1:0] s_sum;
    logic [W-1:0]  s_clip;
    logic          s_sat;

    assign en           = !v_q[2] || bus.out_ready;
    assign bus.in_ready = en;

    for (genvar i = 0; i < SQ2_NTERMS; i++) begin : g_term
        asr_n #(.N(N), .K(sq2_k(i))) u_asr (
            .a_i (bus.a),
            .y_o (term[i])
        );
    end

    // Stage 1: pairwise sums of the six shifted terms.
    assign st1_d = {term[4] + term[5], term[2] + term[3], term[0] + term[1]};

    reg_n_en #(.WIDTH(3*WI)) u_st1 (
        .clk  (clk),
        .rst  (rst),
        .en_i (en),
        .d_i  (st1_d),
        .q_o  (st1_q)
    );

    assign p0_q = st1_q[WI-1:0];
    assign p1_q = st1_q[2*WI-1:WI];
    assign p2_q = st1_q[3*WI-1:2*WI];

    assign st2_d = {p2_q, p0_q + p1_q};

    reg_n_en #(.WIDTH(2*WI)) u_st2 (
        .clk  (clk),
        .rst  (rst),
        .en_i (en),
        .d_i  (st2_d),
        .q_o  (st2_q)
    );

    assign q0_q  = st2_q[WI-1:0];
    assign q1_q  = st2_q[2*WI-1:WI];
    assign s_sum = q0_q + q1_q;

    sat_n #(.N(N)) u_sat (
        .s_i   (s_sum),
        .y_o   (s_clip),
        .sat_o (s_sat)
    );

    assign st3_d = {s_sat, s_clip};

    reg_n_en #(.WIDTH(W+1)) u_st3 (
        .clk  (clk),
        .rst  (rst),
        .en_i (en),
        .d_i  (st3_d),
        .q_o  (st3_q)
    );

    assign v_d = {v_q[1], v_q[0], bus.in_valid};

    reg_n_en #(.WIDTH(3)) u_vld (
        .clk  (clk),
        .rst  (rst),
        .en_i (en),
        .d_i  (v_d),
        .q_o  (v_q)
    );

    assign bus.out_valid = v_q[2];
    assign bus.result    = st3_q[W-1:0];
    assign bus.sat       = st3_q[W];

endmodule

// File: tb/tb_mul_sqrt_2.sv
// Bench for mul_sqrt_2: directed products, backpressure, mid-stream reset and a random soak.
module tb_mul_sqrt_2;
    localparam int N    = 4;
    localparam int W    = 2**N;
    localparam int MAXV = 2**(W-1) - 1;
    localparam int MINV = -(2**(W-1));

    logic clk = 1'b0;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;

    mul_sqrt_2_if #(.N(N)) bus ();

    mul_sqrt_2 #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic longint floor_div(input longint x, input longint d);
        longint q;
        q = x / d;
        if ((x % d != 0) && (x < 0)) q = q - 1;
        return q;
    endfunction

    // x*sqrt(2) approximated as the sum of floor(x / 2^k) over the coefficient terms.
    function automatic logic [W:0] ref_model(input logic [W-1:0] a);
        int           ks [6] = '{0, 2, 3, 5, 7, 13};
        longint       x;
        longint       s;
        logic [W-1:0] r;
        x = longint'($signed(a));
        s = 0;
        foreach (ks[i]) s += floor_div(x, longint'(1) << ks[i]);
        if (s > MAXV) return {1'b1, W'(MAXV)};
        if (s < MINV) return {1'b1, W'(MINV)};
        r = W'(s);
        return {1'b0, r};
    endfunction

    task automatic step(input logic iv, input logic [W-1:0] ia, input logic ordy,
                        output logic in_fire, output logic out_fire,
                        output logic [W-1:0] r, output logic s);
        @(negedge clk);
        bus.in_valid  = iv;
        bus.a         = ia;
        bus.out_ready = ordy;
        #1;
        in_fire  = iv & bus.in_ready;
        out_fire = bus.out_valid & ordy;
        r        = bus.result;
        s        = bus.sat;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_assert++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
        end
        n_assert++;
        if (bus.result !== '0) begin
            n_fail++; $display("FAIL reset_result: got %h want 0", bus.result);
        end
        n_assert++;
        if (bus.sat !== 1'b0) begin
            n_fail++; $display("FAIL reset_sat: got %b want 0", bus.sat);
        end
        n_assert++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_products();
        logic [W-1:0] samp [7] = '{16'h1000, 16'hF000, 16'h0001, 16'hFFFF,
                                   16'h0000, 16'h7FFF, 16'h8000};
        logic [W:0]   want [7] = '{{1'b0, 16'h16A0}, {1'b0, 16'hE95F}, {1'b0, 16'h0001},
                                   {1'b0, 16'hFFFA}, {1'b0, 16'h0000}, {1'b1, 16'h7FFF},
                                   {1'b1, 16'h8000}};
        int ni = 0, no = 0, first_in = -1, first_out = -1, last_out = -1;
        logic inf, outf, s;
        logic [W-1:0] r;
        for (int cyc = 0; cyc < 40 && no < 7; cyc++) begin
            step(ni < 7, samp[ni % 7], 1'b1, inf, outf, r, s);
            if (inf) begin
                if (ni == 0) first_in = cyc;
                ni++;
            end
            if (outf) begin
                if (no == 0) first_out = cyc;
                last_out = cyc;
                n_assert++;
                if ({s, r} !== want[no]) begin
                    n_fail++;
                    $display("FAIL products[%0d]: got sat=%b result=%h want sat=%b result=%h",
                             no, s, r, want[no][W], want[no][W-1:0]);
                end
                no++;
            end
        end
        n_assert++;
        if (no != 7) begin
            n_fail++; $display("FAIL products_count: got %0d want 7", no);
        end
        n_assert++;
        if (first_out - first_in != 3) begin
            n_fail++; $display("FAIL products_latency: got %0d want 3", first_out - first_in);
        end
        n_assert++;
        if (last_out - first_out != 6) begin
            n_fail++; $display("FAIL products_throughput: span %0d want 6", last_out - first_out);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [W-1:0] samp [5];
        logic [W:0]   q [$];
        logic [W:0]   held, w;
        int   ni = 0, no = 0, stalls = 0;
        logic seen = 1'b0, hold_vld = 1'b0, ordy, iv, inf, outf;
        foreach (samp[i]) samp[i] = W'($urandom);
        for (int cyc = 0; cyc < 60 && no < 5; cyc++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
            ordy = !(seen && stalls < 4);
            if (!ordy) stalls++;
            iv = (ni < 5);
            bus.in_valid  = iv;
            bus.a         = samp[ni % 5];
            bus.out_ready = ordy;
            #1;
            inf  = iv & bus.in_ready;
            outf = bus.out_valid & ordy;
            if (!ordy) begin
                n_assert++;
                if (bus.in_ready !== 1'b0) begin
                    n_fail++; $display("FAIL bp_in_ready: got %b want 0", bus.in_ready);
                end
            end
            if (hold_vld) begin
                n_assert++;
                if ({bus.sat, bus.result} !== held) begin
                    n_fail++;
                    $display("FAIL bp_hold: got %h want %h", {bus.sat, bus.result}, held);
                end
            end
            hold_vld = bus.out_valid && !ordy;
            held     = {bus.sat, bus.result};
            if (inf) begin
                q.push_back(ref_model(samp[ni]));
                ni++;
            end
            if (outf) begin
                n_assert++;
                if (q.size() == 0) begin
                    n_fail++; $display("FAIL bp_spurious: output %0d with nothing queued", no);
                end else begin
                    w = q.pop_front();
                    if ({bus.sat, bus.result} !== w) begin
                        n_fail++;
                        $display("FAIL bp_out[%0d]: got %h want %h", no, {bus.sat, bus.result}, w);
                    end
                end
                no++;
            end
        end
        n_assert++;
        if (no != 5 || q.size() != 0 || stalls != 4) begin
            n_fail++;
            $display("FAIL bp_count: got %0d outputs, %0d left, %0d stalls want 5, 0, 4",
                     no, q.size(), stalls);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset_midstream();
        logic inf, outf, s;
        logic [W-1:0] r, a;
        logic [W:0]   w;
        int n_in = 0, n_stale = 0, nout = 0, cin = -1, cout = -1;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, W'($urandom), 1'b1, inf, outf, r, s);
            if (inf) n_in++;
        end
        bus.in_valid = 1'b0;
        n_assert++;
        if (n_in != 3) begin
            n_fail++; $display("FAIL rst_fill: got %0d accepted want 3", n_in);
        end
        @(posedge clk);
        #2;
        n_assert++;
        if (bus.out_valid !== 1'b1) begin
            n_fail++; $display("FAIL rst_pre_valid: got %b want 1", bus.out_valid);
        end
        rst = 1'b1;
        #1;
        n_assert++;
        if (bus.out_valid !== 1'b0 || bus.result !== '0 || bus.sat !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_async_clear: got vld=%b result=%h sat=%b want 0 0 0",
                     bus.out_valid, bus.result, bus.sat);
        end
        n_assert++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, '0, 1'b1, inf, outf, r, s);
            if (outf) n_stale++;
        end
        n_assert++;
        if (n_stale != 0) begin
            n_fail++; $display("FAIL rst_stale: got %0d outputs want 0", n_stale);
        end
        a = W'($urandom);
        w = ref_model(a);
        for (int cyc = 0; cyc < 12 && nout == 0; cyc++) begin
            step(cyc == 0, a, 1'b1, inf, outf, r, s);
            if (inf) cin = cyc;
            if (outf) begin
                cout = cyc;
                nout++;
                n_assert++;
                if ({s, r} !== w) begin
                    n_fail++; $display("FAIL rst_after_value: got %h want %h", {s, r}, w);
                end
            end
        end
        n_assert++;
        if (cin != 0 || cout - cin != 3) begin
            n_fail++; $display("FAIL rst_after_latency: in %0d out %0d want 0 and 3", cin, cout);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_random_soak();
        logic [W-1:0] corners [6] = '{16'h7FFF, 16'h8000, 16'h0000, 16'hFFFF, 16'h5A82, 16'hA57E};
        logic [W:0]   q [$];
        logic [W:0]   held, w;
        logic [W-1:0] a;
        logic iv, ordy, inf, outf, s, hold_vld = 1'b0;
        logic [W-1:0] r;
        int ni = 0, no = 0;
        a = '0;
        for (int cyc = 0; cyc < 60000 && (ni < 10000 || q.size() != 0); cyc++) begin
            if (ni < 10000) begin
                iv = ($urandom_range(0, 9) < 7);
                a  = ($urandom_range(0, 9) == 0) ? corners[$urandom_range(0, 5)] : W'($urandom);
            end else begin
                iv = 1'b0;
            end
            ordy = ($urandom_range(0, 9) < 7);
            step(iv, a, ordy, inf, outf, r, s);
            if (hold_vld) begin
                n_assert++;
                if ({s, r} !== held) begin
                    n_fail++; $display("FAIL soak_hold: got %h want %h", {s, r}, held);
                end
            end
            hold_vld = bus.out_valid && !ordy;
            held     = {s, r};
            if (inf) begin
                q.push_back(ref_model(a));
                ni++;
            end
            if (outf) begin
                n_assert++;
                if (q.size() == 0) begin
                    n_fail++; $display("FAIL soak_spurious: output %0d with nothing queued", no);
                end else begin
                    w = q.pop_front();
                    if ({s, r} !== w) begin
                        n_fail++; $display("FAIL soak_out[%0d]: got %h want %h", no, {s, r}, w);
                    end
                end
                no++;
            end
        end
        n_assert++;
        if (ni != 10000 || no != 10000 || q.size() != 0) begin
            n_fail++;
            $display("FAIL soak_count: in %0d out %0d left %0d want 10000 10000 0",
                     ni, no, q.size());
        end
    endtask

    initial begin
        test_reset();
        test_products();
        test_backpressure();
        test_reset_midstream();
        test_random_soak();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
